// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - 8N1 UART transmitter for a DATA_W-bit result, MSB byte first; optional XOR trailer byte under RESULT_TX_CHECKSUM_EN
`timescale 1ns/1ps

module result_uart_tx #(
  parameter int DATA_W       = 256,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] Q,
  output logic              in_ready,
  output logic              Tx,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int TW     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef RESULT_TX_CHECKSUM_EN
  // The checksum travels as one extra byte after the data bytes.
  localparam int LAST_BYTE = NBYTES;
`else
  localparam int LAST_BYTE = NBYTES - 1;
`endif
  localparam int BW = $clog2(NBYTES + 2);

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(LAST_BYTE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q,    state_d;
  logic              armed_q,    armed_d;
  logic              in_ready_q, in_ready_d;
  logic              tx_q,       tx_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic [DATA_W-1:0] shreg_q,    shreg_d;
  logic [7:0]        cur_byte_q, cur_byte_d;
  logic [BW-1:0]     byte_idx_q, byte_idx_d;
  logic [2:0]        bit_idx_q,  bit_idx_d;
  logic [TW-1:0]     timer_q,    timer_d;
`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0]        csum_q,     csum_d;
`endif

  logic bit_end;

  // Next-state and next-output computation for the whole transmitter.
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shreg_d    = shreg_q;
    cur_byte_d = cur_byte_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    timer_d    = timer_q;
`ifdef RESULT_TX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    bit_end    = (timer_q == T_LAST);

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (in_valid && in_ready_q) begin
          // Byte 0 goes straight to the byte register; the rest wait in shreg.
          cur_byte_d = Q[DATA_W-1 -: 8];
          shreg_d    = Q << 8;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          armed_d    = 1'b0;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          state_d    = S_START;
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d     = Q[DATA_W-1 -: 8];
`endif
        end else if (!in_valid) begin
          // A level-held valid must drop before another result is taken.
          armed_d = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          timer_d    = '0;
          bit_idx_d  = '0;
          tx_d       = cur_byte_q[0];
          cur_byte_d = {1'b0, cur_byte_q[7:1]};
          state_d    = S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d  = bit_idx_q + 3'd1;
            tx_d       = cur_byte_q[0];
            cur_byte_d = {1'b0, cur_byte_q[7:1]};
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (byte_idx_q < B_LAST) begin
            byte_idx_d = byte_idx_q + BW'(1);
            tx_d       = 1'b0;
            state_d    = S_START;
`ifdef RESULT_TX_CHECKSUM_EN
            if (byte_idx_q == BW'(NBYTES - 1)) begin
              cur_byte_d = csum_q;
            end else begin
              cur_byte_d = shreg_q[DATA_W-1 -: 8];
              shreg_d    = shreg_q << 8;
              csum_d     = csum_q ^ shreg_q[DATA_W-1 -: 8];
            end
`else
            cur_byte_d = shreg_q[DATA_W-1 -: 8];
            shreg_d    = shreg_q << 8;
`endif
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Registered so that it reads 0 while reset is held.
    in_ready_d = (state_d == S_IDLE) && armed_d;
  end

  // State registers; reset forces the line idle-high immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      armed_q    <= 1'b1;
      in_ready_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shreg_q    <= '0;
      cur_byte_q <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      timer_q    <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      in_ready_q <= in_ready_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      shreg_q    <= shreg_d;
      cur_byte_q <= cur_byte_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      timer_q    <= timer_d;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign Tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// tb/tb_result_uart_tx.sv - scoreboard bench for result_uart_tx with a UART decoder on Tx
`timescale 1ns/1ps

module tb_result_uart_tx;

  localparam int DW  = 256;
  localparam int CPB = 4;
  localparam int NB  = DW / 8;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int NTX = NB + 1;
`else
  localparam int NTX = NB;
`endif
  localparam int FRAME = NTX * 10 * CPB;

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] Q        = '0;
  logic          in_ready;
  logic          Tx;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb[$];

  result_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .Q        (Q),
    .in_ready (in_ready),
    .Tx       (Tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  // UART decoder: samples mid-bit on falling edges and checks against the scoreboard
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = '0;
  logic [7:0] rx_exp;
  always @(negedge clock) begin
    if (!reset) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (Tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % CPB) == CPB / 2) begin
        if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
          rx_byte[rx_cnt / CPB - 1] = Tx;
        end else if (rx_cnt / CPB == 9) begin
          n_cmp++;
          if (Tx !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_bit: got %b want 1", Tx);
          end
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_byte: got %02h want none", rx_byte);
          end else begin
            rx_exp = sb.pop_front();
            if (rx_byte !== rx_exp) begin
              n_bad++;
              $display("FAIL rx_byte: got %02h want %02h", rx_byte, rx_exp);
            end
          end
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic push_q(input logic [DW-1:0] v);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      b = v[DW-1-8*i -: 8];
      sb.push_back(b);
      x = x ^ b;
    end
`ifdef RESULT_TX_CHECKSUM_EN
    sb.push_back(x);
`endif
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL ready_timeout: got in_ready=%b want 1", in_ready);
    end
  endtask

  // Leaves the caller at 1ns after the acceptance edge.
  task automatic launch(input logic [DW-1:0] v, input bit hold);
    wait_ready();
    Q        = v;
    in_valid = 1'b1;
    push_q(v);
    @(posedge clock);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // el = edges from acceptance to the edge that raised done; -1 on timeout.
  task automatic wait_done(input int k0, output int el);
    el = -1;
    for (int k = k0 + 1; k < k0 + FRAME + 200; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        el = k - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_cmp += 4;
    if (Tx !== 1'b1)       begin n_bad++; $display("FAIL reset_tx: got %b want 1", Tx); end
    if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] v;
    int el;
    for (int i = 0; i < NB; i++) v[DW-1-8*i -: 8] = 8'(i + 1);
    launch(v, 1'b0);
    @(negedge clock);
    n_cmp += 2;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    if (Tx !== 1'b0)   begin n_bad++; $display("FAIL basic_start_bit: got %b want 0", Tx); end
    wait_done(1, el);
    n_cmp += 2;
    if (el != FRAME)   begin n_bad++; $display("FAIL basic_frame_len: got %0d want %0d", el, FRAME); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b want 0", done); end
    repeat (20) @(negedge clock);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL basic_sb_empty: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_bit_format();
    logic [DW-1:0] v;
    logic [9:0]    pat;
    bit            bad;
    int            el;
    pat = 10'b11_0100_1010;
    v = rand_word();
    v[DW-1 -: 8] = 8'hA5;
    n_cmp++;
    if (Tx !== 1'b1) begin n_bad++; $display("FAIL fmt_idle_before: got %b want 1", Tx); end
    launch(v, 1'b0);
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clock);
        if (Tx !== pat[b]) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin n_bad++; $display("FAIL fmt_bit%0d: got %b want %b", b, Tx, pat[b]); end
    end
    wait_done(10 * CPB, el);
    n_cmp++;
    if (el != FRAME) begin n_bad++; $display("FAIL fmt_frame_len: got %0d want %0d", el, FRAME); end
    repeat (10) @(negedge clock);
    n_cmp++;
    if (Tx !== 1'b1) begin n_bad++; $display("FAIL fmt_idle_after: got %b want 1", Tx); end
  endtask

  task automatic test_held_valid();
    logic [DW-1:0] v1, v2;
    int dones, el;
    v1 = rand_word();
    v2 = rand_word();
    launch(v1, 1'b1);
    dones = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
    end
    n_cmp += 2;
    if (dones != 1)    begin n_bad++; $display("FAIL held_done_count: got %0d want 1", dones); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL held_no_retx: got busy=%b want 0", busy); end
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(posedge clock);
    #1;
    Q        = v2;
    in_valid = 1'b1;
    push_q(v2);
    @(posedge clock);
    #1;
    wait_done(0, el);
    in_valid = 1'b0;
    n_cmp++;
    if (el != FRAME) begin n_bad++; $display("FAIL held_rearm_len: got %0d want %0d", el, FRAME); end
    repeat (10) @(negedge clock);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL held_sb_empty: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_busy_ignore();
    logic [DW-1:0] v3, v4;
    int el;
    bit extra;
    v3 = rand_word();
    v4 = ~v3;
    launch(v3, 1'b0);
    repeat (99) @(negedge clock);
    @(posedge clock);
    #1;
    Q        = v4;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    wait_done(100, el);
    n_cmp++;
    if (el != FRAME) begin n_bad++; $display("FAIL ignore_frame_len: got %0d want %0d", el, FRAME); end
    extra = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy !== 1'b0 || Tx !== 1'b1) extra = 1'b1;
    end
    n_cmp += 2;
    if (extra)          begin n_bad++; $display("FAIL ignore_second_frame: got activity want idle"); end
    if (sb.size() != 0) begin n_bad++; $display("FAIL ignore_sb_empty: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] v5, v6;
    int el;
    bit saw_done;
    v5 = rand_word();
    v6 = rand_word();
    launch(v5, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 499; i++) begin
      @(negedge clock);
      if (done === 1'b1) saw_done = 1'b1;
    end
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    n_cmp += 2;
    if (Tx !== 1'b1)   begin n_bad++; $display("FAIL rst_tx_async: got %b want 1", Tx); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy_async: got %b want 0", busy); end
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done === 1'b1) saw_done = 1'b1;
    end
    @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin n_bad++; $display("FAIL rst_no_done: got done want none"); end
    launch(v6, 1'b0);
    wait_done(0, el);
    n_cmp++;
    if (el != FRAME) begin n_bad++; $display("FAIL rst_refrm_len: got %0d want %0d", el, FRAME); end
    repeat (20) @(negedge clock);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL rst_sb_empty: got %0d left want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bit_format();
    test_held_valid();
    test_busy_ignore();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

UART transmitter stage downstream of the 256-bit modular multiplier. Captures the product `Q` when the multiplier asserts its valid, then serialises it as 32 bytes of 8N1 UART on `Tx`, most-significant byte first. Completes the host loop that the `Rx_top` receiver opens: operands come in over UART and the result goes back out over UART.

## Interface
- `DATA_W`, 256: result width in bits; must be a multiple of 8; `NBYTES = DATA_W/8`.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz at 115200 baud); minimum 2.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  result-valid from the multiplier (its `out_valid`); level or pulse.
- `Q`  in  DATA_W  result word; sampled only on acceptance.
- `in_ready`  out  1  high when the block is idle and armed; reset 0.
- `Tx`  out  1  UART line; idle high; reset 1.
- `busy`  out  1  high from acceptance until the last stop bit ends; reset 0.
- `done`  out  1  one-cycle pulse when the last stop bit ends; reset 0.

## Operation
- States: IDLE, START, DATA, STOP. Reset enters IDLE with `armed=1`, `Tx=1`, all counters 0.
- Acceptance: `in_valid && in_ready`. Capture `Q` into the shift register, clear `armed`, set `byte_idx=0`, and go to START.
- `in_ready = (state==IDLE) && armed`.
- Re-arm: `armed` goes to 1 on any cycle in IDLE with `in_valid==0`. A level-held `in_valid` therefore produces exactly one transmission. A new result needs `in_valid` low for at least 1 cycle.
- START: `Tx=0` for one bit time, then go to DATA with `bit_idx=0`.
- DATA: `Tx` is the current byte's bit `bit_idx`, sent LSB first. Each bit lasts one bit time. After bit 7, go to STOP.
- STOP: `Tx=1` for one bit time. Then:
  - if `byte_idx < NBYTES-1`: increment `byte_idx` and go to START;
  - otherwise: pulse `done` and go to IDLE.
- Byte order: byte k is `Q[DATA_W-1-8k -: 8]`, so byte 0 is the MSB byte.
- Bit timer: counts 0..CLKS_PER_BIT-1 and resets on every bit boundary. Width is `$clog2(CLKS_PER_BIT)`.
- `in_valid` while busy is ignored. There is no queueing and no overwrite of the captured word.
- Changes on `Q` after acceptance have no effect on the frame.
- Asserting `reset` mid-frame forces `Tx=1` immediately (asynchronous), goes to IDLE and drops `busy`. No `done` is issued. After release the block is armed.

## Timing
- Acceptance at edge N: the START bit is driven from edge N+1. `busy` is 1 from N+1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. Each byte is 10 bits. There is no inter-byte gap.
- Frame length is `NBYTES*10*CLKS_PER_BIT` cycles, i.e. 320·CLKS_PER_BIT for the default width.
- `done` is high for the single cycle in which STOP of the last byte completes. `busy` falls on the same edge.
- `in_ready` can rise no earlier than the cycle after `done`, and only if `in_valid` is low.
- `Tx` is driven from a register, so it is glitch-free.

## Configuration
- `RESULT_TX_CHECKSUM_EN`
  - Defined: one extra byte is sent after the `NBYTES` data bytes. It is the XOR of all data bytes, accumulated as each byte is loaded. The frame becomes `(NBYTES+1)*10*CLKS_PER_BIT` cycles, and `done` follows the checksum's stop bit.
  - Undefined: no checksum byte and no accumulator logic.

## Test plan
- Basic frame (CLKS_PER_BIT=4): one-cycle `in_valid` with `Q = 0x0102…1F20` (bytes 0x01..0x20 from MSB) -> UART decoder sees 32 bytes 0x01,0x02,…,0x20. `done` pulses exactly 1280 cycles after `busy` rises.
- Bit format: `Q` MSB byte = 0xA5 -> first 10 bits on `Tx` are 0,1,0,1,0,0,1,0,1,1, each held for 4 cycles. The line is idle high before and after the frame.
- Held valid: `in_valid` held at 1 for 3000 cycles -> exactly one frame and one `done`. Dropping `in_valid` for 1 cycle and re-raising it with a new `Q` -> a second frame carrying the new value.
- Busy ignore: a second `in_valid` pulse with a different `Q` at cycle 100 of a frame -> the frame content is unchanged and no second frame is sent.
- Mid-frame reset: `reset`=0 at cycle 500 -> `Tx=1` and `busy=0` in the same cycle, and no `done`. After release, a fresh `in_valid` gives a complete, correct frame.
- With `RESULT_TX_CHECKSUM_EN`: `Q` bytes 0x01..0x20 -> a 33rd byte of 0x20 (the XOR of 1..32) is sent. `done` comes after 1320 cycles.
